// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: register geometry,
// FSM state encoding and the round-robin pointer update.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ZERO   = 0;

    // Width of the requester index (up to four requesters).
    localparam int GRANT_W    = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_t;

    // Round-robin pointer after a grant to idx: the requester after idx, wrapping.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int num_req);
        if (int'(idx) >= num_req - 1)
            return '0;
        else
            return GRANT_W'(int'(idx) + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts at ptr and wraps
// modulo NUM_REQ; the first valid requester wins.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               any_grant
);

    // Scan requesters in priority order ptr, ptr+1, ... and pick the first valid one.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_grant && valid[i] && ((int'(ptr) + k) % NUM_REQ == i)) begin
                    grant[i]  = 1'b1;
                    grant_idx = GRANT_W'(i);
                    any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the single register-file write port. After reset it sweeps
// registers 1..31 to zero, then shares the port between NUM_REQ requesters
// with round-robin valid/ready arbitration and a one-cycle registered write.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter int DATA_W         = REG_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [GRANT_W-1:0]        grant_id,
    output logic                      init_done
);

    arb_state_t         state;
    logic [ADDR_W-1:0]  clr_ptr;
    logic [GRANT_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [GRANT_W-1:0] grant_idx;
    logic               any_grant;
    logic               handshake;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Ready is offered only while arbitrating; the sweep owns the port otherwise.
    assign req_ready = (state == ST_ARB) ? grant : '0;
    assign handshake = (state == ST_ARB) && any_grant;

    // Select the granted requester's address and data from the packed buses.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                gnt_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clear-sweep / arbitration FSM with registered write-port outputs.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!ctrl_reset_n) begin
            state            <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            clr_ptr          <= ADDR_W'(1);
            rr_ptr           <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            grant_id         <= '0;
            // Without a sweep the port is usable straight out of reset.
            init_done        <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= clr_ptr;
                    data_writeReg    <= '0;
                    clr_ptr          <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(REG_COUNT - 1)) begin
                        state     <= ST_ARB;
                        init_done <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (handshake) begin
                        grant_id <= grant_idx;
                        rr_ptr   <= rr_next(grant_idx, NUM_REQ);
                        if (gnt_addr == ADDR_W'(REG_ZERO)) begin
                            // Register 0 is hardwired: accept the request, write nothing.
                            ctrl_writeEnable <= 1'b0;
                        end else begin
                            ctrl_writeEnable <= 1'b1;
                            ctrl_writeReg    <= gnt_addr;
                            data_writeReg    <= gnt_data;
                        end
                    end else begin
                        ctrl_writeEnable <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sweep, a table of
// arbitration vectors, a mid-sweep reset and a no-sweep build.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        ctrl_reset_n;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;

    logic [1:0]  req_ready;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  gid;
    logic        init_done;

    logic [1:0]  ready2;
    logic        we2;
    logic [4:0]  wreg2;
    logic [31:0] wdata2;
    logic [1:0]  gid2;
    logic        init2;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .NUM_REQ(2), .ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
        .data_writeReg(wdata), .grant_id(gid), .init_done(init_done)
    );

    regfile_write_arbiter #(
        .NUM_REQ(2), .ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b0)
    ) dut_noclr (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(ready2), .ctrl_writeEnable(we2), .ctrl_writeReg(wreg2),
        .data_writeReg(wdata2), .grant_id(gid2), .init_done(init2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [1:0]  gid;
        logic        chk_bus;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    // Follow the sweep for 'steps' cycles starting at register 1.
    task automatic run_sweep(input int steps);
        for (int k = 1; k <= steps; k++) begin
            @(negedge clock);
            check($sformatf("sweep_we_%0d", k), 64'(we), 64'd1);
            check($sformatf("sweep_reg_%0d", k), 64'(wreg), 64'(k));
            check($sformatf("sweep_data_%0d", k), 64'(wdata), 64'd0);
            check($sformatf("sweep_init_%0d", k), 64'(init_done), 64'(k == 31));
            if (k < 31)
                check($sformatf("sweep_ready_%0d", k), 64'(req_ready), 64'd0);
            if (k == 30)
                req_valid = 2'b00;
        end
    endtask

    initial begin
        // valid, a0, d0, a1, d1 | ready, we, wreg, wdata, gid, chk_bus
        vecs[0]  = '{2'b11, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002, 2'b01, 1'b1, 5'd5, 32'hAAAA_0001, 2'd0, 1'b1};
        vecs[1]  = '{2'b11, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002, 2'b10, 1'b1, 5'd6, 32'hBBBB_0002, 2'd1, 1'b1};
        vecs[2]  = '{2'b11, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002, 2'b01, 1'b1, 5'd5, 32'hAAAA_0001, 2'd0, 1'b1};
        vecs[3]  = '{2'b11, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002, 2'b10, 1'b1, 5'd6, 32'hBBBB_0002, 2'd1, 1'b1};
        vecs[4]  = '{2'b10, 5'd0, 32'h0,         5'd9, 32'h1111_0009, 2'b10, 1'b1, 5'd9, 32'h1111_0009, 2'd1, 1'b1};
        vecs[5]  = '{2'b10, 5'd0, 32'h0,         5'd9, 32'h1111_0009, 2'b10, 1'b1, 5'd9, 32'h1111_0009, 2'd1, 1'b1};
        vecs[6]  = '{2'b10, 5'd0, 32'h0,         5'd9, 32'h1111_0009, 2'b10, 1'b1, 5'd9, 32'h1111_0009, 2'd1, 1'b1};
        vecs[7]  = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 1'b0, 5'd9, 32'h1111_0009, 2'd1, 1'b1};
        vecs[8]  = '{2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0,         2'b01, 1'b0, 5'd0, 32'h0,         2'd0, 1'b0};
        vecs[9]  = '{2'b01, 5'd3, 32'h0000_3333, 5'd0, 32'h0,         2'b01, 1'b1, 5'd3, 32'h0000_3333, 2'd0, 1'b1};
        vecs[10] = '{2'b11, 5'd7, 32'h0000_0007, 5'd7, 32'h0000_0008, 2'b10, 1'b1, 5'd7, 32'h0000_0008, 2'd1, 1'b1};
        vecs[11] = '{2'b11, 5'd7, 32'h0000_0007, 5'd7, 32'h0000_0008, 2'b01, 1'b1, 5'd7, 32'h0000_0007, 2'd0, 1'b1};
        vecs[12] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b00, 1'b0, 5'd7, 32'h0000_0007, 2'd0, 1'b1};

        // Reset with both requesters asking: nothing may be granted.
        ctrl_reset_n = 1'b0;
        drive(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        @(negedge clock);
        @(negedge clock);
        check("rst_we", 64'(we), 64'd0);
        check("rst_reg", 64'(wreg), 64'd0);
        check("rst_data", 64'(wdata), 64'd0);
        check("rst_gid", 64'(gid), 64'd0);
        check("rst_init", 64'(init_done), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        // Full sweep with valid held high until the final step.
        ctrl_reset_n = 1'b1;
        run_sweep(31);

        // Arbitration vectors: ready checked combinationally, write one cycle later.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            @(negedge clock);
            check($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].we));
            check($sformatf("vec%0d_gid", i), 64'(gid), 64'(vecs[i].gid));
            if (vecs[i].chk_bus) begin
                check($sformatf("vec%0d_reg", i), 64'(wreg), 64'(vecs[i].wreg));
                check($sformatf("vec%0d_data", i), 64'(wdata), 64'(vecs[i].wdata));
            end
        end

        // Reset during traffic, then reset pulse at sweep step 10.
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        check("rst2_we", 64'(we), 64'd0);
        check("rst2_init", 64'(init_done), 64'd0);
        ctrl_reset_n = 1'b1;
        run_sweep(10);
        ctrl_reset_n = 1'b0;
        @(negedge clock);
        check("midrst_we", 64'(we), 64'd0);
        check("midrst_init", 64'(init_done), 64'd0);
        check("midrst_reg", 64'(wreg), 64'd0);
        ctrl_reset_n = 1'b1;
        run_sweep(31);

        // Build without the sweep: ready and init_done in the first cycle after reset.
        ctrl_reset_n = 1'b0;
        drive(2'b01, 5'd12, 32'h0000_C0DE, 5'd0, 32'h0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        check("noclr_init", 64'(init2), 64'd1);
        check("noclr_ready", 64'(ready2), 64'b01);
        check("clr_ready_blocked", 64'(req_ready), 64'd0);
        @(negedge clock);
        check("noclr_we", 64'(we2), 64'd1);
        check("noclr_reg", 64'(wreg2), 64'd12);
        check("noclr_data", 64'(wdata2), 64'h0000_C0DE);
        check("noclr_gid", 64'(gid2), 64'd0);
        check("clr_sweep_first", 64'(wreg), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
